// File: rtl/seq_det_ctrl.sv
// -----------------------------------------------------------------------------
// seq_det_ctrl
//
// Purpose:
//   Scans a captured 16-bit word MSB-first into an external overlapping "1011"
//   Mealy sequence detector. Each scan starts with the detector freshly reset.
//   The block counts detections, records whether any occurred, and records the
//   scan index of the first one. A scan can be cancelled with abort. The
//   results of the last scan stay visible until the next accepted start.
//
// Ports:
//   clk        in   1   sole clock, rising edge
//   rstn       in   1   asynchronous active-low reset
//   start      in   1   scan request, sampled only in IDLE
//   data_in    in  16   word to scan (MSB first), captured on accepted start
//   len        in   5   bits to scan; 0 or >16 means 16
//   abort      in   1   synchronous cancel of an active scan
//   ser_out    out  1   serial bit to the detector input
//   det_rstn   out  1   active-low detector reset, released only in SHIFT
//   detected   in   1   detector Mealy output (combinational on ser_out)
//   busy       out  1   high in SHIFT and DONE
//   done       out  1   one-cycle pulse in DONE
//   match_cnt  out  3   detections in the last scan, saturating at 7
//   found      out  1   at least one detection in the last scan
//   first_idx  out  4   scan index of the first detection's last bit (0 if none)
// -----------------------------------------------------------------------------
module seq_det_ctrl (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic [15:0] data_in,
    input  logic [4:0]  len,
    input  logic        abort,
    output logic        ser_out,
    output logic        det_rstn,
    input  logic        detected,
    output logic        busy,
    output logic        done,
    output logic [2:0]  match_cnt,
    output logic        found,
    output logic [3:0]  first_idx
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [15:0] r_shift;
    logic [4:0]  r_len;
    logic [3:0]  r_idx;
    logic [2:0]  r_match_cnt;
    logic        r_found;
    logic [3:0]  r_first_idx;

    logic        w_start_acc;
    logic        w_last;
    logic [4:0]  w_len_eff;

    assign w_start_acc = (r_state == ST_IDLE) && start;
    assign w_len_eff   = ((len == 5'd0) || (len > 5'd16)) ? 5'd16 : len;
    // r_len is always 1..16, so r_len-1 never underflows.
    assign w_last      = (r_state == ST_SHIFT) && ({1'b0, r_idx} == (r_len - 5'd1));

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; abort takes priority over the final shift cycle
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_next = ST_SHIFT;
            ST_SHIFT: begin
                if (abort)       w_next = ST_IDLE;
                else if (w_last) w_next = ST_DONE;
            end
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Output decode from the state register only
    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        det_rstn = 1'b0;
        case (r_state)
            ST_SHIFT: begin
                busy     = 1'b1;
                det_rstn = 1'b1;
            end
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Shift register, bit index and result registers.
    // The shift register is cleared whenever SHIFT is left, so its MSB can
    // drive ser_out directly and still read 0 in IDLE and DONE.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_shift     <= 16'd0;
            r_len       <= 5'd16;
            r_idx       <= 4'd0;
            r_match_cnt <= 3'd0;
            r_found     <= 1'b0;
            r_first_idx <= 4'd0;
        end else if (w_start_acc) begin
            r_shift     <= data_in;
            r_len       <= w_len_eff;
            r_idx       <= 4'd0;
            r_match_cnt <= 3'd0;
            r_found     <= 1'b0;
            r_first_idx <= 4'd0;
        end else if (r_state == ST_SHIFT) begin
            if (abort) begin
                // Detection on the abort edge is discarded; partial results kept.
                r_shift <= 16'd0;
            end else begin
                r_shift <= w_last ? 16'd0 : {r_shift[14:0], 1'b0};
                r_idx   <= r_idx + 4'd1;
                if (detected) begin
                    if (r_match_cnt != 3'd7) r_match_cnt <= r_match_cnt + 3'd1;
                    if (!r_found) begin
                        r_found     <= 1'b1;
                        r_first_idx <= r_idx;
                    end
                end
            end
        end
    end

    assign ser_out   = r_shift[15];
    assign match_cnt = r_match_cnt;
    assign found     = r_found;
    assign first_idx = r_first_idx;

endmodule

// File: tb/tb_seq_det_ctrl.sv
module tb_seq_det_ctrl;

    logic        clk;
    logic        rstn;
    logic        start;
    logic [15:0] data_in;
    logic [4:0]  len;
    logic        abort;
    logic        ser_out;
    logic        det_rstn;
    logic        detected;
    logic        busy;
    logic        done;
    logic [2:0]  match_cnt;
    logic        found;
    logic [3:0]  first_idx;

    int checks = 0;
    int errors = 0;

    seq_det_ctrl dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .data_in   (data_in),
        .len       (len),
        .abort     (abort),
        .ser_out   (ser_out),
        .det_rstn  (det_rstn),
        .detected  (detected),
        .busy      (busy),
        .done      (done),
        .match_cnt (match_cnt),
        .found     (found),
        .first_idx (first_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External overlapping 1011 Mealy detector the controller drives.
    // States: 0 = nothing, 1 = "1", 2 = "10", 3 = "101".
    logic [1:0] det_st;
    always_ff @(posedge clk or negedge det_rstn) begin
        if (!det_rstn) det_st <= 2'd0;
        else begin
            case (det_st)
                2'd0: det_st <= ser_out ? 2'd1 : 2'd0;
                2'd1: det_st <= ser_out ? 2'd1 : 2'd2;
                2'd2: det_st <= ser_out ? 2'd3 : 2'd0;
                default: det_st <= ser_out ? 2'd1 : 2'd2;
            endcase
        end
    end
    assign detected = (det_st == 2'd3) && ser_out;

    // Reference: effective length and pattern search over the bit string.
    function automatic int eff_len(input logic [4:0] l);
        return (l == 5'd0 || l > 5'd16) ? 16 : int'(l);
    endfunction

    // Expected results after n bits of word d have been scanned.
    task automatic ref_scan(input logic [15:0] d, input int n,
                            output logic [2:0] cnt, output logic fnd,
                            output logic [3:0] fidx);
        int c;
        c = 0; fnd = 1'b0; fidx = 4'd0;
        for (int k = 3; k < n; k++) begin
            if (d[18-k] == 1'b1 && d[17-k] == 1'b0 && d[16-k] == 1'b1 && d[15-k] == 1'b1) begin
                if (c < 7) c++;
                if (!fnd) begin
                    fnd  = 1'b1;
                    fidx = 4'(k);
                end
            end
        end
        cnt = 3'(c);
    endtask

    // Called at a negedge while IDLE; returns at the negedge of the IDLE cycle
    // after DONE. With noise, start/abort/other data are driven during SHIFT
    // and DONE and must all be ignored.
    task automatic run_scan(input logic [15:0] d, input logic [4:0] l,
                            input bit noise, input string tag);
        int n;
        logic [2:0] ecnt;
        logic efnd;
        logic [3:0] efidx;
        n = eff_len(l);
        ref_scan(d, n, ecnt, efnd, efidx);
        start = 1'b1; data_in = d; len = l;
        @(negedge clk);
        start = 1'b0; data_in = 16'($urandom); len = 5'($urandom);
        for (int k = 0; k < n; k++) begin
            checks++;
            if (ser_out !== d[15-k]) begin
                errors++;
                $display("FAIL %s ser_out k=%0d got %b exp %b", tag, k, ser_out, d[15-k]);
            end
            checks++;
            if ({busy, done, det_rstn} !== 3'b101) begin
                errors++;
                $display("FAIL %s shift_status k=%0d got busy/done/det_rstn=%b exp 101", tag, k, {busy, done, det_rstn});
            end
            if (noise) begin
                start = 1'($urandom); data_in = ~d; len = 5'($urandom);
            end
            @(negedge clk);
        end
        checks++;
        if ({busy, done, det_rstn, ser_out} !== 4'b1100) begin
            errors++;
            $display("FAIL %s done_status got busy/done/det_rstn/ser=%b exp 1100", tag, {busy, done, det_rstn, ser_out});
        end
        checks++;
        if ({match_cnt, found, first_idx} !== {ecnt, efnd, efidx}) begin
            errors++;
            $display("FAIL %s results got cnt=%0d found=%b first=%0d exp cnt=%0d found=%b first=%0d",
                     tag, match_cnt, found, first_idx, ecnt, efnd, efidx);
        end
        if (noise) begin
            start = 1'b1; data_in = ~d; abort = 1'b1;
        end
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        checks++;
        if ({busy, done, det_rstn, ser_out} !== 4'b0000) begin
            errors++;
            $display("FAIL %s idle_status got busy/done/det_rstn/ser=%b exp 0000", tag, {busy, done, det_rstn, ser_out});
        end
        checks++;
        if ({match_cnt, found, first_idx} !== {ecnt, efnd, efidx}) begin
            errors++;
            $display("FAIL %s results_stable got cnt=%0d found=%b first=%0d exp cnt=%0d found=%b first=%0d",
                     tag, match_cnt, found, first_idx, ecnt, efnd, efidx);
        end
    endtask

    // Abort asserted during SHIFT cycle ak; ends at the negedge two cycles after.
    task automatic run_abort(input logic [15:0] d, input logic [4:0] l,
                             input int ak, input string tag);
        logic [2:0] ecnt;
        logic efnd;
        logic [3:0] efidx;
        ref_scan(d, ak, ecnt, efnd, efidx);
        start = 1'b1; data_in = d; len = l;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k <= ak; k++) begin
            checks++;
            if (ser_out !== d[15-k]) begin
                errors++;
                $display("FAIL %s ser_out k=%0d got %b exp %b", tag, k, ser_out, d[15-k]);
            end
            if (k == ak) abort = 1'b1;
            @(negedge clk);
        end
        abort = 1'b0;
        checks++;
        if ({busy, done, det_rstn, ser_out} !== 4'b0000) begin
            errors++;
            $display("FAIL %s abort_status got busy/done/det_rstn/ser=%b exp 0000", tag, {busy, done, det_rstn, ser_out});
        end
        checks++;
        if ({match_cnt, found, first_idx} !== {ecnt, efnd, efidx}) begin
            errors++;
            $display("FAIL %s abort_results got cnt=%0d found=%b first=%0d exp cnt=%0d found=%b first=%0d",
                     tag, match_cnt, found, first_idx, ecnt, efnd, efidx);
        end
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL %s no_done_after_abort got busy/done=%b exp 00", tag, {busy, done});
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; start = 1'b0; abort = 1'b0; data_in = 16'h0; len = 5'd0;
        #1;
        checks++;
        if ({busy, done, ser_out, det_rstn, match_cnt, found, first_idx} !== 12'd0) begin
            errors++;
            $display("FAIL reset_outputs got %b exp 0", {busy, done, ser_out, det_rstn, match_cnt, found, first_idx});
        end
        repeat (3) @(negedge clk);
        start = 1'b1;  // must be ignored while in reset
        @(negedge clk);
        checks++;
        if ({busy, done, det_rstn} !== 3'b000) begin
            errors++;
            $display("FAIL reset_hold got busy/done/det_rstn=%b exp 000", {busy, done, det_rstn});
        end
        start = 1'b0;
        rstn = 1'b1;
    endtask

    task automatic test_vectors();
        run_scan(16'hB6B7, 5'd16, 1'b0, "vec_b6b7_16");
        run_scan(16'hB6B7, 5'd5,  1'b0, "vec_b6b7_5");
        run_scan(16'h0000, 5'd0,  1'b0, "vec_zero_0");
        run_scan(16'hB6DB, 5'd16, 1'b0, "vec_b6db_16");
        run_scan(16'hB6DB, 5'd31, 1'b0, "vec_b6db_31");
        run_scan(16'hFFFF, 5'd1,  1'b0, "vec_ffff_1");
        // Direct pin-down of the headline vector independent of the model.
        checks++;
        run_scan(16'hB6B7, 5'd16, 1'b0, "vec_b6b7_again");
        if ({match_cnt, found, first_idx} !== {3'd4, 1'b1, 4'd3}) begin
            errors++;
            $display("FAIL vec_b6b7_const got cnt=%0d found=%b first=%0d exp 4 1 3", match_cnt, found, first_idx);
        end
    endtask

    task automatic test_ignore_start();
        run_scan(16'hB6B7, 5'd16, 1'b1, "ign_first");
        run_scan(16'hB6DB, 5'd16, 1'b0, "ign_second");
        run_scan(16'h2D2D, 5'd12, 1'b1, "ign_third");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 30; i++) begin
            run_scan(16'($urandom), 5'($urandom), 1'($urandom), $sformatf("rand%0d", i));
        end
    endtask

    task automatic test_abort();
        run_abort(16'hB6B7, 5'd16, 5, "abort_k5");
        run_abort(16'hB6B7, 5'd7, 6, "abort_last");
        run_abort(16'hB6B7, 5'd16, 0, "abort_k0");
        for (int i = 0; i < 10; i++) begin
            logic [4:0] l;
            l = 5'($urandom);
            run_abort(16'($urandom), l, $urandom_range(0, eff_len(l) - 1), $sformatf("abort_rand%0d", i));
        end
        run_scan(16'hB6B7, 5'd16, 1'b0, "after_abort");
    endtask

    task automatic test_abort_idle();
        logic [2:0] c0;
        logic f0;
        logic [3:0] i0;
        c0 = match_cnt; f0 = found; i0 = first_idx;
        abort = 1'b1;
        repeat (2) @(negedge clk);
        abort = 1'b0;
        checks++;
        if ({busy, done, match_cnt, found, first_idx} !== {2'b00, c0, f0, i0}) begin
            errors++;
            $display("FAIL abort_idle got busy/done=%b cnt=%0d found=%b first=%0d exp 00 %0d %b %0d",
                     {busy, done}, match_cnt, found, first_idx, c0, f0, i0);
        end
    endtask

    task automatic test_reset_mid();
        start = 1'b1; data_in = 16'hB6B7; len = 5'd16;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);   // now in SHIFT k=5, one detection counted
        #2 rstn = 1'b0;
        #1;
        checks++;
        if ({busy, done, ser_out, det_rstn, match_cnt, found, first_idx} !== 12'd0) begin
            errors++;
            $display("FAIL reset_mid got %b exp 0", {busy, done, ser_out, det_rstn, match_cnt, found, first_idx});
        end
        @(negedge clk);
        rstn = 1'b1;
        run_scan(16'hB6DB, 5'd16, 1'b0, "after_reset");
    endtask

    initial begin
        test_reset();
        @(negedge clk);
        test_vectors();
        test_ignore_start();
        test_back_to_back();
        test_abort();
        test_abort_idle();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
